// File: rtl/spi_slave_ram_if.sv
// SPI pin bundle between a mode-0 master and the RAM slave.
// valid/ready: none; SPI is self-timed by SCLK, CSN frames each transfer.
interface spi_slave_ram_if;
    logic CSN;
    logic SCLK;
    logic MOSI;
    logic MISO;

    modport master (output CSN, output SCLK, output MOSI, input MISO);
    modport slave  (input CSN, input SCLK, input MOSI, output MISO);
endinterface

// File: rtl/spi_slave_ram.sv
// SPI mode-0 slave fronting a small register file. All pins are oversampled
// by CLK; a frame is R/W bit, address MSB first, then data MSB first.
module spi_slave_ram #(
    parameter int DATA_BIT = 4,
    parameter int ADDR_BIT = 3
) (
    input  logic                CLK,
    input  logic                RST,
    spi_slave_ram_if.slave      spi,
    output logic                WR_STB,
    output logic                RD_STB,
    output logic [ADDR_BIT-1:0] LAST_ADDR,
    output logic [DATA_BIT-1:0] LAST_DATA,
    output logic [2:0]          state_dbg
);
    localparam int DEPTH = 1 << ADDR_BIT;
    localparam int MAXB  = (ADDR_BIT > DATA_BIT) ? ADDR_BIT : DATA_BIT;
    localparam int CNT_W = $clog2(MAXB + 1);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] ADDR    = 3'd2;
    localparam logic [2:0] DATA    = 3'd3;
    localparam logic [2:0] WAIT_CS = 3'd4;

    logic [2:0]          state;
    logic                csn_s1, csn_s2;
    logic                sclk_s1, sclk_s2, sclk_s3;
    logic                mosi_s1, mosi_s2;
    logic                sclk_rise, sclk_fall;
    logic                rw;
    logic [CNT_W-1:0]    cnt;
    logic [ADDR_BIT-1:0] addr;
    logic [DATA_BIT-1:0] shreg;
    logic [DATA_BIT-1:0] rd_word;
    logic                commit_pend, load_pend, rd_done_pend;
    logic                miso_q;
    logic [DATA_BIT-1:0] ram [DEPTH];

    assign sclk_rise = sclk_s2 & ~sclk_s3;
    assign sclk_fall = ~sclk_s2 & sclk_s3;
    assign spi.MISO  = miso_q;
    assign state_dbg = state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            csn_s1       <= 1'b1;
            csn_s2       <= 1'b1;
            sclk_s1      <= 1'b0;
            sclk_s2      <= 1'b0;
            sclk_s3      <= 1'b0;
            mosi_s1      <= 1'b0;
            mosi_s2      <= 1'b0;
            rw           <= 1'b0;
            cnt          <= '0;
            addr         <= '0;
            shreg        <= '0;
            rd_word      <= '0;
            commit_pend  <= 1'b0;
            load_pend    <= 1'b0;
            rd_done_pend <= 1'b0;
            miso_q       <= 1'b0;
            WR_STB       <= 1'b0;
            RD_STB       <= 1'b0;
            LAST_ADDR    <= '0;
            LAST_DATA    <= '0;
            for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
        end else begin
            csn_s1  <= spi.CSN;
            csn_s2  <= csn_s1;
            sclk_s1 <= spi.SCLK;
            sclk_s2 <= sclk_s1;
            sclk_s3 <= sclk_s2;
            mosi_s1 <= spi.MOSI;
            mosi_s2 <= mosi_s1;
            WR_STB  <= 1'b0;
            RD_STB  <= 1'b0;

            // Completed-frame actions run one CLK after the deciding SCLK rise.
            if (commit_pend) begin
                ram[addr]   <= shreg;
                WR_STB      <= 1'b1;
                LAST_ADDR   <= addr;
                LAST_DATA   <= shreg;
                commit_pend <= 1'b0;
            end
            if (load_pend) begin
                shreg     <= ram[addr];
                rd_word   <= ram[addr];
                LAST_ADDR <= addr;
                load_pend <= 1'b0;
            end
            if (rd_done_pend) begin
                RD_STB       <= 1'b1;
                LAST_DATA    <= rd_word;
                rd_done_pend <= 1'b0;
            end

            if (state == IDLE) begin
                miso_q <= 1'b0;
                if (!csn_s2) state <= CMD;
            end else if (csn_s2) begin
                // CSN high beats any SCLK edge seen in the same cycle.
                state  <= IDLE;
                miso_q <= 1'b0;
            end else begin
                case (state)
                    CMD: begin
                        if (sclk_rise) begin
                            rw    <= mosi_s2;
                            cnt   <= '0;
                            addr  <= '0;
                            state <= ADDR;
                        end
                    end
                    ADDR: begin
                        if (sclk_rise) begin
                            addr <= (addr << 1) | ADDR_BIT'(mosi_s2);
                            if (cnt == CNT_W'(ADDR_BIT - 1)) begin
                                cnt   <= '0;
                                state <= DATA;
                                if (!rw) load_pend <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (sclk_rise) begin
                            if (rw) shreg <= (shreg << 1) | DATA_BIT'(mosi_s2);
                            if (cnt == CNT_W'(DATA_BIT - 1)) begin
                                cnt    <= '0;
                                state  <= WAIT_CS;
                                miso_q <= 1'b0;
                                if (rw) commit_pend  <= 1'b1;
                                else    rd_done_pend <= 1'b1;
                            end else begin
                                cnt <= cnt + CNT_W'(1);
                            end
                        end else if (sclk_fall && !rw) begin
                            miso_q <= shreg[DATA_BIT-1];
                            shreg  <= shreg << 1;
                        end
                    end
                    WAIT_CS: begin
                        miso_q <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        miso_q <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_slave_ram.sv
// Directed bench for spi_slave_ram: a behavioural SPI master drives frames
// and the expected RAM contents/strobes are hand-computed constants.
module tb_spi_slave_ram;
    logic       clk;
    logic       rst;
    logic       wr_stb, rd_stb;
    logic [2:0] last_addr;
    logic [3:0] last_data;
    logic [2:0] state_dbg;

    spi_slave_ram_if bus();

    spi_slave_ram #(.DATA_BIT(4), .ADDR_BIT(3)) dut (
        .CLK       (clk),
        .RST       (rst),
        .spi       (bus),
        .WR_STB    (wr_stb),
        .RD_STB    (rd_stb),
        .LAST_ADDR (last_addr),
        .LAST_DATA (last_data),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int wr_cnt = 0;
    int rd_cnt = 0;
    int wr_cyc = 0;
    int rise_cyc = 0;
    int miso_hi = 0;
    logic in_wr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_stb) begin
            wr_cnt <= wr_cnt + 1;
            wr_cyc <= cyc;
        end
        if (rd_stb) rd_cnt <= rd_cnt + 1;
        if (in_wr && bus.MISO) miso_hi <= miso_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // n_bits rises are sent; rst_at>=0 pulses RST before that bit and stops the frame.
    task automatic spi_frame(input logic rw, input logic [2:0] a, input logic [3:0] d,
                             input int n_bits, input int extra, input int rst_at,
                             output logic [3:0] rdata);
        logic [7:0] fr;
        fr = {rw, a, d};
        rdata = '0;
        @(negedge clk);
        in_wr = rw;
        bus.CSN = 1'b0;
        for (int i = 0; i < n_bits; i++) begin
            bus.MOSI = fr[7-i];
            repeat (5) @(negedge clk);
            if (i == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check("rst_wr_stb", {31'd0, wr_stb}, 32'd0);
                check("rst_rd_stb", {31'd0, rd_stb}, 32'd0);
                check("rst_miso", {31'd0, bus.MISO}, 32'd0);
                check("rst_last_addr", {29'd0, last_addr}, 32'd0);
                check("rst_last_data", {28'd0, last_data}, 32'd0);
                check("rst_state", {29'd0, state_dbg}, 32'd0);
                break;
            end
            bus.SCLK = 1'b1;
            rise_cyc = cyc;
            if (i >= 4) rdata[7-i] = bus.MISO;
            repeat (5) @(negedge clk);
            bus.SCLK = 1'b0;
        end
        for (int k = 0; k < extra; k++) begin
            bus.MOSI = 1'b1;
            repeat (5) @(negedge clk);
            bus.SCLK = 1'b1;
            repeat (5) @(negedge clk);
            bus.SCLK = 1'b0;
        end
        repeat (5) @(negedge clk);
        bus.CSN = 1'b1;
        bus.MOSI = 1'b0;
        repeat (8) @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] a, input logic [3:0] d);
        logic [3:0] dummy;
        spi_frame(1'b1, a, d, 8, 0, -1, dummy);
    endtask

    task automatic do_read(input logic [2:0] a, output logic [3:0] rdata);
        spi_frame(1'b0, a, 4'($urandom_range(0, 15)), 8, 0, -1, rdata);
    endtask

    logic [3:0] rd;
    int w0, r0;

    initial begin
        rst = 1'b1;
        bus.CSN = 1'b1;
        bus.SCLK = 1'b0;
        bus.MOSI = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_miso", {31'd0, bus.MISO}, 32'd0);
        check("reset_wr_stb", {31'd0, wr_stb}, 32'd0);
        check("reset_rd_stb", {31'd0, rd_stb}, 32'd0);
        check("reset_last_addr", {29'd0, last_addr}, 32'd0);
        check("reset_last_data", {28'd0, last_data}, 32'd0);
        check("reset_state", {29'd0, state_dbg}, 32'd0);

        // 1: read of cleared RAM
        r0 = rd_cnt;
        do_read(3'b101, rd);
        check("t1_rdata", {28'd0, rd}, 32'h0);
        check("t1_rd_pulses", rd_cnt - r0, 32'd1);
        check("t1_last_addr", {29'd0, last_addr}, 32'd5);
        check("t1_last_data", {28'd0, last_data}, 32'h0);

        // 2: write then read back, with commit latency
        w0 = wr_cnt;
        do_write(3'b101, 4'hA);
        check("t2_wr_pulses", wr_cnt - w0, 32'd1);
        check("t2_wr_latency", wr_cyc - rise_cyc, 32'd4);
        check("t2_last_addr", {29'd0, last_addr}, 32'd5);
        check("t2_last_data", {28'd0, last_data}, 32'hA);
        r0 = rd_cnt;
        do_read(3'b101, rd);
        check("t2_rdata", {28'd0, rd}, 32'hA);
        check("t2_rd_pulses", rd_cnt - r0, 32'd1);
        check("t2_rd_last_data", {28'd0, last_data}, 32'hA);

        // 3: two writes, independent reads
        do_write(3'b010, 4'h5);
        do_write(3'b011, 4'hC);
        do_read(3'b010, rd);
        check("t3_rd2", {28'd0, rd}, 32'h5);
        do_read(3'b011, rd);
        check("t3_rd3", {28'd0, rd}, 32'hC);
        check("t3_last_data", {28'd0, last_data}, 32'hC);
        do_read(3'b111, rd);
        check("t3_rd7", {28'd0, rd}, 32'h0);

        // 4: abort after two data bits
        w0 = wr_cnt;
        spi_frame(1'b1, 3'b101, 4'h3, 6, 0, -1, rd);
        check("t4_no_wr", wr_cnt - w0, 32'd0);
        do_read(3'b101, rd);
        check("t4_rd5", {28'd0, rd}, 32'hA);

        // 5: extra SCLK pulses after a complete write
        w0 = wr_cnt;
        spi_frame(1'b1, 3'b100, 4'h6, 8, 3, -1, rd);
        check("t5_wr_pulses", wr_cnt - w0, 32'd1);
        check("t5_miso_quiet", miso_hi, 32'd0);
        do_read(3'b100, rd);
        check("t5_rd4", {28'd0, rd}, 32'h6);
        check("t5_miso_idle", {31'd0, bus.MISO}, 32'd0);

        // 6: reset during the address phase of a write
        w0 = wr_cnt;
        spi_frame(1'b1, 3'b010, 4'hF, 8, 0, 2, rd);
        check("t6_no_wr", wr_cnt - w0, 32'd0);
        do_read(3'b010, rd);
        check("t6_rd2_cleared", {28'd0, rd}, 32'h0);
        do_read(3'b100, rd);
        check("t6_rd4_cleared", {28'd0, rd}, 32'h0);
        check("t6_last_addr", {29'd0, last_addr}, 32'd4);
        check("t6_miso_total", miso_hi, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_slave_ram.md
Name: spi_slave_ram

Overview:
SPI slave (mode 0, MSB first) with an internal 2^ADDR_BIT x DATA_BIT register file. It sits directly downstream of the SPI master: it consumes CSN/SCLK/MOSI and returns MISO. The master uses it as the remote RAM target for its write and read commands. All SPI pins are oversampled by the system clock; there is no SCLK-domain logic.

Parameters:
DATA_BIT, 4, data word width and register-file width.
ADDR_BIT, 3, address width; depth = 2**ADDR_BIT.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous active-high reset.
CSN  input  1  chip select, active low, asynchronous to CLK.
SCLK  input  1  serial clock from master, asynchronous to CLK, idle low.
MOSI  input  1  serial data from master.
MISO  output  1  serial data to master.
WR_STB  output  1  one-CLK pulse when a write frame commits to RAM.
RD_STB  output  1  one-CLK pulse when a read frame has shifted out its last data bit.
LAST_ADDR  output  ADDR_BIT  address of the most recent completed or started data phase.
LAST_DATA  output  DATA_BIT  data written, or data read, by the most recent completed frame.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - MISO=0, WR_STB=0, RD_STB=0, LAST_ADDR=0, LAST_DATA=0.
  - All RAM words cleared to 0.
  - Synchronizers preset to the idle levels CSN=1, SCLK=0, MOSI=0.
  - FSM goes to IDLE.
  - Reset mid-frame discards the frame; no RAM write occurs.
- Input path:
  - CSN, SCLK and MOSI each pass through a 2-flop synchronizer.
  - A third register on SCLK gives rise/fall detection.
  - A pin edge is acted on 3 CLK after it occurs.
  - Requirements on the master: SCLK high and low phases each >= 4 CLK; MOSI stable around the SCLK rise.
- Frame format (sampled on SCLK rising edge), 1 + ADDR_BIT + DATA_BIT bits:
  - bit 0: R/W, where 1=write and 0=read.
  - next ADDR_BIT bits: address, MSB first.
  - next DATA_BIT bits: data, MSB first. For a write, MOSI carries the data; for a read, MOSI is don't-care.
- FSM states: IDLE, CMD, ADDR, DATA, WAIT_CS.
  - IDLE -> CMD on synchronized CSN falling.
  - CMD: first SCLK rise latches R/W -> ADDR.
  - ADDR: bit counter counts ADDR_BIT rises, then -> DATA.
  - DATA: counts DATA_BIT rises, then -> WAIT_CS.
  - WAIT_CS: all further SCLK edges are ignored; synchronized CSN high -> IDLE.
  - In any state other than IDLE, synchronized CSN high -> IDLE immediately (abort). An aborted write frame does not commit; an aborted read frame does not pulse RD_STB.
- Write commit:
  - On the CLK after the last data rise is detected, RAM[addr] <= shifted data.
  - In the same CLK, WR_STB=1 for exactly 1 CLK, LAST_ADDR=addr, LAST_DATA=data.
- Read:
  - On the CLK after the last address rise is detected, load the shift register with RAM[addr] and set LAST_ADDR=addr.
  - MISO is updated only on detected SCLK falling edges.
  - On the fall following the last address bit, MISO = data MSB; each later fall shifts to the next bit.
  - On the CLK after the last data rise, RD_STB=1 for 1 CLK and LAST_DATA = word read.
  - Read data is the RAM content at the time of the load.
- MISO = 0 whenever the FSM is not in DATA for a read frame (IDLE, CMD, ADDR, WAIT_CS, any write frame). No tristate.
- Simultaneous events: if a CSN rise and an SCLK rise are detected in the same CLK, CSN wins (abort). WR_STB and RD_STB are never both high.
- Address wraps naturally over ADDR_BIT bits; no out-of-range case exists.

Test Plan:
1. Reset, then read addr 3'b101 (frame 0,101,xxxx) -> MISO shifts 0,0,0,0; RD_STB pulses once; LAST_DATA=0.
2. Write frame 1,101,1010 with SCLK period 10 CLK -> one WR_STB pulse 4 CLK after the final SCLK rise; LAST_ADDR=5, LAST_DATA=4'hA. Then read addr 5 -> MISO 1,0,1,0 sampled on master rises; RD_STB pulses; LAST_DATA=4'hA.
3. Write 1,010,0101 then write 1,011,1100, then read both -> 4'h5 and 4'hC. Reading addr 7 returns 0 (unaffected).
4. Abort: write 1,101,0011 with CSN raised after 2 data bits -> no WR_STB; subsequent read of addr 5 returns the prior value 4'hA; next frame decodes normally.
5. Extra SCLK: a complete write frame followed by 3 extra SCLK pulses before CSN rises -> exactly one WR_STB; MISO stays 0; RAM holds the frame data only.
6. RST=1 for 1 CLK during the ADDR phase of a write -> all outputs 0, no WR_STB. After CSN cycles high, a fresh read of the written address returns 0 (RAM cleared).
